// File: rtl/vec_cordic_vectoring.sv
// vec_cordic_vectoring: iterative vectoring CORDIC, (x, y) -> magnitude (gain K included) and phase at 4096 LSB/rad
module vec_cordic_vectoring #(
  parameter int WIDTH      = 16,
  parameter int WIDTH_WIRE = 18,
  parameter int ITER       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH_WIRE-1:0] x_in,
  input  logic signed [WIDTH_WIRE-1:0] y_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [WIDTH_WIRE-1:0] mag_out,
  output logic        [WIDTH-1:0]      phase_out
);
  localparam int XW = WIDTH_WIRE + 1;
  localparam int ZW = WIDTH + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2;
  localparam logic [12*16-1:0] ANG = {16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'd64,
                                      16'd128, 16'd256, 16'd509, 16'd1003, 16'd1899, 16'd3217};
  localparam logic signed [ZW-1:0] P90 = ZW'(6433), P180 = ZW'(12867), P270 = ZW'(19301), P360 = ZW'(25735);
  logic [1:0] state;
  logic signed [XW-1:0] x, y, xe, ye, fx, fy, xs, ys, xn, yn;
  logic signed [ZW-1:0] z, fz, a, zn;
  logic [WIDTH-1:0] phase_nx;
  logic [3:0] i;
  logic xneg, yneg, neg, last;
  assign in_ready = (state == S_IDLE);
  // fold the input into the first quadrant so the iterations only need to cover +-pi/2
  always_comb begin
    xe       = {x_in[WIDTH_WIRE-1], x_in};
    ye       = {y_in[WIDTH_WIRE-1], y_in};
    xneg     = xe[XW-1];
    yneg     = ye[XW-1];
    fx       = !xneg ? (!yneg ? xe : -ye) : (!yneg ? ye : -xe);
    fy       = !xneg ? (!yneg ? ye : xe) : (!yneg ? -xe : -ye);
    fz       = !xneg ? (!yneg ? '0 : P270) : (!yneg ? P90 : P180);
    a        = ZW'(ANG[{i, 4'b0} +: 16]);
    xs       = x >>> i;
    ys       = y >>> i;
    neg      = y[XW-1];
    xn       = neg ? x - ys : x + ys;
    yn       = neg ? y + xs : y - xs;
    zn       = neg ? z - a : z + a;
    phase_nx = WIDTH'(zn < 0 ? zn + P360 : (zn >= P360 ? zn - P360 : zn));
    last     = (i == 4'(ITER - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      out_valid <= 1'b0;
      mag_out   <= '0;
      phase_out <= '0;
    end else if (state == S_IDLE && in_valid) begin
      x     <= fx;
      y     <= fy;
      z     <= fz;
      i     <= '0;
      state <= S_ITER;
    end else if (state == S_ITER) begin
      x <= xn;
      y <= yn;
      z <= zn;
      i <= i + 4'd1;
      if (last) begin
        state     <= S_DONE;
        out_valid <= 1'b1;
        mag_out   <= xn[WIDTH_WIRE-1:0];
        phase_out <= phase_nx;
      end
    end else if (state == S_DONE && out_ready) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule
